// File: rtl/jtdd_rom_arb.sv
// rtl/jtdd_rom_arb.sv - N-slot ROM read arbiter with one cached 32-bit SDRAM line per slot
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   downloading    ROM download in progress: flushes caches, aborts fetch, drops ready
//   slot_cs        per-slot read request (level)
//   slot_addr      per-slot byte (8-bit slot) or halfword (16-bit slot) address, packed SAW bits each
//   slot_ok        registered: slot_dout valid for the current slot_addr
//   slot_dout      per-slot 16-bit data, 8-bit slots zero-extended
//   sdram_req      read request towards the SDRAM controller, held until sdram_ack
//   sdram_addr     SDRAM 16-bit word address of the requested line (even)
//   sdram_ack      controller accepted the request (pulse)
//   data_rdy       data_read valid (pulse)
//   data_read      32-bit line, lower word address in [15:0]
//   refresh_en     controller may refresh (idle, nothing pending)
//   ready          arbiter operational
module jtdd_rom_arb #(
    parameter int                  SLOTS   = 4,
    parameter int                  SAW     = 19,
    parameter logic [SLOTS*22-1:0] OFFSETS = '0,
    parameter logic [SLOTS-1:0]    DW16    = '0,
    parameter bit                  RR_MODE = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 downloading,
    input  logic [SLOTS-1:0]     slot_cs,
    input  logic [SLOTS*SAW-1:0] slot_addr,
    output logic [SLOTS-1:0]     slot_ok,
    output logic [SLOTS*16-1:0]  slot_dout,
    output logic                 sdram_req,
    output logic [21:0]          sdram_addr,
    input  logic                 sdram_ack,
    input  logic                 data_rdy,
    input  logic [31:0]          data_read,
    output logic                 refresh_en,
    output logic                 ready
);

    localparam int PW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t            state, state_nxt;
    logic [31:0]       line_data [SLOTS];
    logic [SAW-1:0]    line_tag  [SLOTS];
    logic [SLOTS-1:0]  line_valid;
    logic [SAW-1:0]    cur_tag   [SLOTS];
    logic [21:0]       cur_addr  [SLOTS];
    logic [15:0]       cur_data  [SLOTS];
    logic [SLOTS-1:0]  hit, miss;
    logic              any_miss;
    logic [PW-1:0]     win, win_q, rr_ptr;
    logic [SAW-1:0]    tag_q;
    logic              grant, fill;

    // Per-slot tag, line address, data lane select and hit detection
    for (genvar g = 0; g < SLOTS; g++) begin : g_slot
        logic [SAW-1:0] a;
        assign a = slot_addr[g*SAW +: SAW];
        if (DW16[g]) begin : g_w16
            assign cur_tag[g]  = {1'b0, a[SAW-1:1]};
            assign cur_data[g] = a[0] ? line_data[g][31:16] : line_data[g][15:0];
        end else begin : g_w8
            assign cur_tag[g]  = {2'b00, a[SAW-1:2]};
            assign cur_data[g] = {8'h00, line_data[g][{a[1:0], 3'b000} +: 8]};
        end
        // Word address wraps naturally at 22 bits
        assign cur_addr[g] = OFFSETS[22*g +: 22] + 22'({cur_tag[g], 1'b0});
        assign hit[g]      = slot_cs[g] & line_valid[g] & (line_tag[g] == cur_tag[g]);
        assign miss[g]     = slot_cs[g] & ~hit[g];
    end

    // Misses only count once the arbiter is operational
    assign any_miss = ready & (|miss);

    // Winner search: from index 0 (fixed) or from the slot after the last grant (round-robin)
    always_comb begin
        int  idx;
        logic found;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < SLOTS; i++) begin
            idx = RR_MODE ? int'(rr_ptr) + 1 + i : i;
            if (idx >= SLOTS) idx = idx - SLOTS;
            if (!found && miss[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        fill      = 1'b0;
        if (downloading) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (any_miss) begin
                    grant     = 1'b1;
                    state_nxt = REQ;
                end
                // ack and data in the same cycle completes the fetch at once
                REQ: if (sdram_ack) begin
                    if (data_rdy) begin
                        fill      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
                WAIT: if (data_rdy) begin
                    fill      = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign sdram_req  = (state == REQ) & ~downloading;
    assign refresh_en = (state == IDLE) & ~any_miss;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready      <= 1'b0;
            win_q      <= '0;
            tag_q      <= '0;
            sdram_addr <= '0;
            rr_ptr     <= PW'(SLOTS - 1);
        end else begin
            ready <= ~downloading;
            if (grant) begin
                win_q      <= win;
                tag_q      <= cur_tag[win];
                sdram_addr <= cur_addr[win];
                rr_ptr     <= win;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_valid <= '0;
            slot_ok    <= '0;
            slot_dout  <= '0;
        end else begin
            if (downloading)  line_valid        <= '0;
            else if (fill)    line_valid[win_q] <= 1'b1;
            slot_ok <= hit & {SLOTS{~downloading}};
            for (int i = 0; i < SLOTS; i++)
                if (hit[i]) slot_dout[16*i +: 16] <= cur_data[i];
        end
    end

    // The line is stored under the tag latched at grant, even if the client moved since
    always_ff @(posedge clk) begin
        if (fill) begin
            line_data[win_q] <= data_read;
            line_tag[win_q]  <= tag_q;
        end
    end

endmodule

// File: tb/tb_jtdd_rom_arb.sv
// tb/tb_jtdd_rom_arb.sv - self-checking bench for jtdd_rom_arb
module tb_jtdd_rom_arb;

    localparam int SLOTS = 4;
    localparam int SAW   = 19;
    localparam logic [SLOTS*22-1:0] OFFS = {22'h3FFFFE, 22'h020000, 22'h000000, 22'h014000};
    localparam logic [SLOTS-1:0]    DWM  = 4'b1010;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic downloading = 1'b0;

    logic [SLOTS-1:0]     cs = '0;
    logic [SLOTS*SAW-1:0] addr = '0;
    logic [SLOTS-1:0]     ok;
    logic [SLOTS*16-1:0]  dout;
    logic                 req, ack = 1'b0, rdy = 1'b0, refresh, ready;
    logic [21:0]          sd_addr;
    logic [31:0]          rdata = '0;

    logic [SLOTS-1:0]     fcs = '0;
    logic [SLOTS*SAW-1:0] faddr = '0;
    logic [SLOTS-1:0]     fok;
    logic [SLOTS*16-1:0]  fdout;
    logic                 freq, fack = 1'b0, frdy = 1'b0, frefresh, fready;
    logic [21:0]          fsd_addr;
    logic [31:0]          frdata = '0;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    jtdd_rom_arb #(.SLOTS(SLOTS), .SAW(SAW), .OFFSETS(OFFS), .DW16(DWM), .RR_MODE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .downloading(downloading),
        .slot_cs(cs), .slot_addr(addr), .slot_ok(ok), .slot_dout(dout),
        .sdram_req(req), .sdram_addr(sd_addr), .sdram_ack(ack), .data_rdy(rdy),
        .data_read(rdata), .refresh_en(refresh), .ready(ready)
    );

    jtdd_rom_arb #(.SLOTS(SLOTS), .SAW(SAW), .OFFSETS(OFFS), .DW16(DWM), .RR_MODE(1'b0)) dut_fx (
        .clk(clk), .rst_n(rst_n), .downloading(downloading),
        .slot_cs(fcs), .slot_addr(faddr), .slot_ok(fok), .slot_dout(fdout),
        .sdram_req(freq), .sdram_addr(fsd_addr), .sdram_ack(fack), .data_rdy(frdy),
        .data_read(frdata), .refresh_en(frefresh), .ready(fready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of the RR instance ----------------
    int   offs [SLOTS] = '{'h014000, 'h000000, 'h020000, 'h3FFFFE};
    bit   dw   [SLOTS] = '{1'b0, 1'b1, 1'b0, 1'b1};
    bit          m_valid [SLOTS];
    int          m_tag   [SLOTS];
    logic [31:0] m_data  [SLOTS];
    bit          exp_ok  [SLOTS];
    logic [15:0] exp_dout[SLOTS];
    bit   m_busy = 0, m_acked = 0, m_ready = 0;
    int   m_slot = 0, m_tagl = 0, m_ptr = SLOTS - 1;
    logic [21:0] exp_addr = '0;

    function automatic int addr_of(int s);
        return int'(addr[s*SAW +: SAW]);
    endfunction

    function automatic int tag_of(int s, int a);
        return dw[s] ? a / 2 : a / 4;
    endfunction

    function automatic logic [15:0] pick(int s, int a, logic [31:0] line);
        if (dw[s]) return 16'((line >> (16 * (a % 2))) & 32'hFFFF);
        return 16'((line >> (8 * (a % 4))) & 32'hFF);
    endfunction

    function automatic logic [21:0] line_addr(int s, int a);
        return 22'((offs[s] + 2 * tag_of(s, a)) % (1 << 22));
    endfunction

    function automatic bit m_hit(int s);
        return cs[s] && m_valid[s] && (m_tag[s] == tag_of(s, addr_of(s)));
    endfunction

    function automatic bit m_anymiss();
        for (int s = 0; s < SLOTS; s++)
            if (cs[s] && !m_hit(s)) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < SLOTS; s++) begin
                m_valid[s] = 0; exp_ok[s] = 0; exp_dout[s] = '0;
            end
            m_busy = 0; m_acked = 0; m_ready = 0; m_ptr = SLOTS - 1; exp_addr = '0;
        end else begin
            bit h [SLOTS];
            bit pend;
            for (int s = 0; s < SLOTS; s++) h[s] = m_hit(s);
            pend = m_anymiss();
            for (int s = 0; s < SLOTS; s++) begin
                exp_ok[s] = h[s] && !downloading;
                if (h[s]) exp_dout[s] = pick(s, addr_of(s), m_data[s]);
            end
            if (downloading) begin
                for (int s = 0; s < SLOTS; s++) m_valid[s] = 0;
                m_busy = 0;
            end else if (m_busy) begin
                if (!m_acked) begin
                    if (ack) begin
                        m_acked = 1;
                        if (rdy) begin
                            m_valid[m_slot] = 1; m_tag[m_slot] = m_tagl; m_data[m_slot] = rdata; m_busy = 0;
                        end
                    end
                end else if (rdy) begin
                    m_valid[m_slot] = 1; m_tag[m_slot] = m_tagl; m_data[m_slot] = rdata; m_busy = 0;
                end
            end else if (m_ready && pend) begin
                for (int k = 1; k <= SLOTS; k++) begin
                    int s;
                    s = (m_ptr + k) % SLOTS;
                    if (!m_busy && cs[s] && !h[s]) begin
                        m_busy = 1; m_acked = 0; m_slot = s;
                        m_tagl = tag_of(s, addr_of(s));
                        exp_addr = line_addr(s, addr_of(s));
                    end
                end
                m_ptr = m_slot;
            end
            m_ready = !downloading;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            bit er;
            for (int s = 0; s < SLOTS; s++) begin
                chk($sformatf("ok%0d", s), 32'(ok[s]), 32'(exp_ok[s]));
                if (exp_ok[s]) chk($sformatf("dout%0d", s), 32'(dout[16*s +: 16]), 32'(exp_dout[s]));
            end
            er = m_busy && !m_acked && !downloading;
            chk("sdram_req", 32'(req), 32'(er));
            if (er) chk("sdram_addr", 32'(sd_addr), 32'(exp_addr));
            chk("ready", 32'(ready), 32'(m_ready));
            chk("refresh_en", 32'(refresh), 32'(!m_busy && !(m_ready && m_anymiss())));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Wait for a request, ack after ack_dly cycles, optionally move a client address
    // while waiting for data, then return data after data_dly cycles (0: with ack, <0: never)
    task automatic serve(input bit fx, input logic [31:0] d, input int ack_dly, input int data_dly,
                         input int mv_slot, input int mv_addr, output logic [21:0] cap);
        int n;
        bit got;
        n = 0; got = 0; cap = '0;
        while (n < 60) begin
            if ((fx ? freq : req) === 1'b1) begin got = 1; break; end
            step(1); n++;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL serve_timeout: got no sdram_req expected one within 60 cycles");
            return;
        end
        cap = fx ? fsd_addr : sd_addr;
        step(ack_dly);
        if (fx) fack = 1'b1; else ack = 1'b1;
        if (data_dly == 0) begin
            if (fx) begin frdy = 1'b1; frdata = d; end else begin rdy = 1'b1; rdata = d; end
        end
        step(1);
        fack = 1'b0; ack = 1'b0; frdy = 1'b0; rdy = 1'b0;
        if (mv_slot >= 0) begin
            if (fx) faddr[mv_slot*SAW +: SAW] = SAW'(mv_addr);
            else    addr[mv_slot*SAW +: SAW]  = SAW'(mv_addr);
        end
        if (data_dly > 0) begin
            step(data_dly - 1);
            if (fx) begin frdy = 1'b1; frdata = d; end else begin rdy = 1'b1; rdata = d; end
            step(1);
            frdy = 1'b0; rdy = 1'b0;
        end
    endtask

    logic [21:0] rr_exp [5] = '{22'h014080, 22'h000100, 22'h020080, 22'h0000FE, 22'h014100};
    int          rr_mv  [5] = '{0, 1, 2, 3, 0};
    int          rr_to  [5] = '{'h200, 'h200, 'h200, 'h200, 'h300};
    logic [21:0] fx_exp [4] = '{22'h014080, 22'h014100, 22'h014180, 22'h000100};

    initial begin
        logic [21:0] cap;
        step(2);
        @(negedge clk);
        chk("rst_req", 32'(req), 0);
        chk("rst_addr", 32'(sd_addr), 0);
        chk("rst_ok", 32'(ok), 0);
        chk("rst_dout", dout[31:0], 0);
        chk("rst_refresh", 32'(refresh), 1);
        chk("rst_ready", 32'(ready), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1);
        chk("ready_up", 32'(ready), 1);

        // 8-bit slot, OFFSET 0x14000, byte address 5
        cs[0] = 1'b1; addr[0*SAW +: SAW] = 19'h00005;
        serve(0, 32'hA1B2C3D4, 2, 3, -1, 0, cap);
        chk("a_addr", 32'(cap), 32'h014002);
        step(1);
        chk("a_ok", 32'(ok[0]), 1);
        chk("a_dout", 32'(dout[15:0]), 32'h00C3);
        addr[0*SAW +: SAW] = 19'h00006;
        step(1);
        chk("a_hit_ok", 32'(ok[0]), 1);
        chk("a_hit_dout", 32'(dout[15:0]), 32'h00B2);
        chk("a_hit_noreq", 32'(req), 0);

        // stray data_rdy while idle must be ignored
        rdy = 1'b1; rdata = 32'hDEADBEEF;
        step(1);
        rdy = 1'b0;
        step(1);

        // 16-bit slot, ack and data in the same cycle
        cs[1] = 1'b1; addr[1*SAW +: SAW] = 19'h00003;
        serve(0, 32'h12345678, 1, 0, -1, 0, cap);
        chk("b_addr", 32'(cap), 32'h000002);
        step(1);
        chk("b_dout", 32'(dout[31:16]), 32'h1234);

        // 16-bit slot whose line address wraps past 2^22
        cs[3] = 1'b1; addr[3*SAW +: SAW] = 19'h00002;
        serve(0, 32'hCAFEF00D, 0, 1, -1, 0, cap);
        chk("c_addr", 32'(cap), 32'h000000);
        step(1);
        chk("c_dout", 32'(dout[63:48]), 32'hF00D);

        // Round-robin: all slots keep missing (each winner moves during its fetch)
        for (int s = 0; s < SLOTS; s++) addr[s*SAW +: SAW] = 19'h00100;
        cs = 4'hF;
        for (int k = 0; k < 5; k++) begin
            serve(0, 32'h11111111 * (k + 1), 1, 2, rr_mv[k], rr_to[k], cap);
            chk($sformatf("rr_grant%0d", k), 32'(cap), 32'(rr_exp[k]));
        end
        chk("rr_no_ok", 32'(ok), 0);
        cs = '0;
        step(3);

        // Fixed priority: slot 0 wins while it misses
        for (int s = 0; s < SLOTS; s++) faddr[s*SAW +: SAW] = 19'h00100;
        fcs = 4'hF;
        for (int k = 0; k < 4; k++) begin
            serve(1, 32'h55AA55AA, 1, 2, (k < 3) ? 0 : -1, 'h200 + 'h100 * k, cap);
            chk($sformatf("fx_grant%0d", k), 32'(cap), 32'(fx_exp[k]));
            if (k == 2) fcs[0] = 1'b0;
        end
        fcs = '0;
        step(3);

        // Download pulse while waiting for data
        cs[0] = 1'b1; addr[0*SAW +: SAW] = 19'h00005;
        serve(0, 32'h0, 1, -1, -1, 0, cap);
        chk("d_first_addr", 32'(cap), 32'h014002);
        downloading = 1'b1;
        step(1);
        chk("d_req", 32'(req), 0);
        chk("d_ok", 32'(ok), 0);
        chk("d_ready", 32'(ready), 0);
        rdy = 1'b1; rdata = 32'h99999999;
        step(1);
        rdy = 1'b0;
        step(1);
        downloading = 1'b0;
        step(1);
        chk("d_ready_up", 32'(ready), 1);
        serve(0, 32'hA1B2C3D4, 1, 1, -1, 0, cap);
        chk("d_refetch_addr", 32'(cap), 32'h014002);
        step(1);
        chk("d_refetch_dout", 32'(dout[15:0]), 32'h00C3);

        // Reset asserted mid-fetch
        addr[0*SAW +: SAW] = 19'h00009;
        serve(0, 32'h0, 1, -1, -1, 0, cap);
        rst_n = 1'b0;
        #1;
        chk("r_req", 32'(req), 0);
        chk("r_ready", 32'(ready), 0);
        step(2);
        rst_n = 1'b1;
        serve(0, 32'h0BADF00D, 1, 1, -1, 0, cap);
        chk("r_refetch_addr", 32'(cap), 32'h014004);
        step(1);
        chk("r_dout", 32'(dout[15:0]), 32'h00F0);
        cs = '0;
        step(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500000");
        $fatal(1);
    end

endmodule
